// File: rtl/byte_serial_logic_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// logic_seq_pkg
// Shared constants for the byte-serial logic sequencer.
//   - OP_*  : 2-bit opcode encodings accepted on the opcode port
//   - state_e: FSM state encodings (S_IDLE, S_RUN, S_DONE)
// ---------------------------------------------------------------------------
package logic_seq_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_ANDN = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/byte_serial_logic_ctrl_slice.sv
// ---------------------------------------------------------------------------
// logic_slice_8
// Purely combinational 8-bit bitwise logic slice.
// Ports:
//   a_i      [7:0] first operand byte
//   b_i      [7:0] second operand byte
//   opcode_i [1:0] OP_AND / OP_OR / OP_XOR / OP_ANDN
//   y_o      [7:0] selected result byte
// ---------------------------------------------------------------------------
module logic_slice_8
    import logic_seq_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [1:0] opcode_i,
    output logic [7:0] y_o
);

    logic [7:0] b_and;
    logic [7:0] and_y;
    logic [7:0] or_y;
    logic [7:0] xor_y;

    // ANDN shares the AND gate array; only the b input is inverted.
    assign b_and = (opcode_i == OP_ANDN) ? ~b_i : b_i;
    assign and_y = a_i & b_and;
    assign or_y  = a_i | b_i;
    assign xor_y = a_i ^ b_i;

    always_comb begin
        y_o = and_y;
        case (opcode_i)
            OP_OR:   y_o = or_y;
            OP_XOR:  y_o = xor_y;
            default: y_o = and_y;
        endcase
    end

endmodule

// File: rtl/byte_serial_logic_ctrl.sv
// ---------------------------------------------------------------------------
// byte_serial_logic_ctrl
// 32-bit bitwise logic (AND/OR/XOR/ANDN) computed one byte per cycle through
// a single 8-bit slice, LSB first. Valid/ready on both sides.
// Ports:
//   clock, reset          clock; synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready = state IDLE)
//   opcode [1:0]          00 AND, 01 OR, 10 XOR, 11 ANDN (a & ~b)
//   operand_a, operand_b  DATA_WIDTH operands
//   out_valid / out_ready result handshake (out_valid = state DONE)
//   result                DATA_WIDTH result register
//   busy                  state is RUN
//   zero                  result == 0 (only with LOGIC_SEQ_ZERO_FLAG_EN)
// Build option: define LOGIC_SEQ_ZERO_FLAG_EN to add the zero flag.
//
// state  | meaning
// IDLE   | waiting for an operation, in_ready=1
// RUN    | processing byte[cnt] through the slice
// DONE   | result held, out_valid=1 until out_ready
// ---------------------------------------------------------------------------
module byte_serial_logic_ctrl
    import logic_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32
)
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            opcode,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    ,
    output logic                  zero
`endif
);

    localparam int NUM_SLICES = DATA_WIDTH / 8;
    localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [DATA_WIDTH-1:0] a_q,     a_d;
    logic [DATA_WIDTH-1:0] b_q,     b_d;
    logic [DATA_WIDTH-1:0] res_q,   res_d;
    logic [1:0]            op_q,    op_d;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    logic                  zero_q,  zero_d;
`endif

    logic [7:0] slice_a;
    logic [7:0] slice_b;
    logic [7:0] slice_y;

    assign slice_a = a_q[{cnt_q, 3'b000} +: 8];
    assign slice_b = b_q[{cnt_q, 3'b000} +: 8];

    logic_slice_8 u_slice (
        .a_i      (slice_a),
        .b_i      (slice_b),
        .opcode_i (op_q),
        .y_o      (slice_y)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
        zero_d  = zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = operand_a;
                    b_d     = operand_b;
                    op_d    = opcode;
                    res_d   = '0;
                    cnt_d   = '0;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
                    zero_d  = 1'b1;
`endif
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d[{cnt_q, 3'b000} +: 8] = slice_y;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
                if (slice_y != 8'h00) begin
                    zero_d = 1'b0;
                end
`endif
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_AND;
            res_q   <= '0;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
            zero_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN);
    assign out_valid = (state_q == S_DONE);
    assign result    = res_q;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    assign zero      = zero_q;
`endif

endmodule
